mc_mem_responder: RTL and testbench



---
 rtl/mc_mem_pkg.sv | 29 ++
 rtl/mc_mem_responder_if.sv | 30 +++
 rtl/mc_word_ram.sv | 41 ++++
 rtl/mc_mem_responder.sv | 148 ++++++++++++++
 tb/tb_mc_mem_responder.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_mem_pkg
//  Purpose  : Shared types and constants for the multi-cycle memory responder:
//             FSM state encoding, word size, error read-data value, the legal
//             wait-state maximum and the address legality check.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int          WORD_BYTES      = 4;
  localparam logic [31:0] ERR_RDATA       = 32'h0;
  localparam int          WAIT_CYCLES_MAX = 15;

  // A request is illegal when it is not word aligned or when any byte-address
  // bit above the word-index field is set.
  function automatic logic addr_is_bad(input logic [31:0] addr, input int aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : mc_mem_responder_if
//  Purpose  : Request/response bundle between the core (master) and the
//             memory responder (slave).
//  Signals  : req_valid/req_ready handshake, req_we, req_addr (byte address),
//             req_wdata; resp_valid pulse, resp_rdata, resp_err.
//  Revision : 1.0 - initial release
// ============================================================================
interface mc_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/mc_word_ram.sv
`default_nettype none
// ============================================================================
//  Module   : mc_word_ram
//  Purpose  : 2**ADDR_WIDTH x 32 word memory, one synchronous write port and
//             one synchronous read port with read enable. The read register
//             only changes when i_re is high, so its value is held between
//             reads. Contents are not reset.
//  Ports    : clk, i_we/i_waddr/i_wdata (write), i_re/i_raddr (read),
//             o_rdata (registered read data)
//  Revision : 1.0 - initial release
// ============================================================================
module mc_word_ram #(
  parameter int ADDR_WIDTH = 6
) (
  input  wire logic                  clk,
  input  wire logic                  i_we,
  input  wire logic [ADDR_WIDTH-1:0] i_waddr,
  input  wire logic [31:0]           i_wdata,
  input  wire logic                  i_re,
  input  wire logic [ADDR_WIDTH-1:0] i_raddr,
  output logic      [31:0]           o_rdata
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] r_mem [c_DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mc_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : mc_mem_responder
//  Purpose  : Memory-side responder for the multi-cycle core's shared memory
//             port. Accepts one request at a time, waits WAIT_CYCLES busy
//             cycles, then pulses resp_valid for one cycle with read data and
//             an error flag. A side-band load port preloads memory while idle.
//  Ports    : clk, reset (async, active high)
//             bus        - slave side of mc_mem_responder_if
//             i_load_en  - preload strobe (honoured only in IDLE)
//             i_load_addr- preload word index
//             i_load_data- preload data
//  Revision : 1.0 - initial release
// ============================================================================
module mc_mem_responder
  import mc_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  wire logic                  clk,
  input  wire logic                  reset,
  mc_mem_responder_if.slave          bus,
  input  wire logic                  i_load_en,
  input  wire logic [ADDR_WIDTH-1:0] i_load_addr,
  input  wire logic [31:0]           i_load_data
);

  localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic        r_rdata_sel;   // 1: present RAM read data, 0: present ERR_RDATA

  logic                  w_in_idle;
  logic                  w_req_ready;
  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_op_we;
  logic [31:0]           w_op_addr;
  logic [31:0]           w_op_wdata;
  logic                  w_op_err;
  logic [ADDR_WIDTH-1:0] w_index;
  logic                  w_mem_we;
  logic                  w_mem_re;
  logic                  w_load_we;
  logic                  w_ram_we;
  logic [ADDR_WIDTH-1:0] w_ram_waddr;
  logic [31:0]           w_ram_wdata;
  logic [31:0]           w_ram_q;

  assign w_in_idle   = (r_state == ST_IDLE);
  // Load has priority over a request; nothing is accepted while reset is held.
  assign w_req_ready = w_in_idle & ~i_load_en & ~reset;
  assign w_accept    = bus.req_valid & w_req_ready;

  // With zero wait states the access happens on the accept edge itself, so
  // the live request fields are used instead of the (not yet loaded) capture.
  assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == ST_BUSY) && (r_cnt == 4'd0));
  assign w_op_we      = w_in_idle ? bus.req_we    : r_we;
  assign w_op_addr    = w_in_idle ? bus.req_addr  : r_addr;
  assign w_op_wdata   = w_in_idle ? bus.req_wdata : r_wdata;
  assign w_op_err     = addr_is_bad(w_op_addr, ADDR_WIDTH);
  assign w_index      = w_op_addr[ADDR_WIDTH+1:2];

  assign w_mem_we  = w_enter_resp & w_op_we  & ~w_op_err;
  assign w_mem_re  = w_enter_resp & ~w_op_we & ~w_op_err;
  assign w_load_we = w_in_idle & i_load_en & ~reset;

  // Load and request writes never collide: a request write from IDLE needs
  // an acceptance, which a pending load blocks.
  assign w_ram_we    = w_load_we | w_mem_we;
  assign w_ram_waddr = w_load_we ? i_load_addr : w_index;
  assign w_ram_wdata = w_load_we ? i_load_data : w_op_wdata;

  mc_word_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_mem_re),
    .i_raddr (w_index),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_rdata_sel  <= 1'b0;
    end else begin
      r_resp_valid <= w_enter_resp;
      if (w_enter_resp) begin
        r_resp_err  <= w_op_err;
        r_rdata_sel <= w_mem_re;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            if (WAIT_CYCLES == 0) begin
              r_state <= ST_RESP;
            end else begin
              r_cnt   <= c_WAIT_LOAD;
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = r_rdata_sel ? w_ram_q : ERR_RDATA;

endmodule
`default_nettype wire

// File: tb/tb_mc_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_mem_responder
//  Purpose  : Self-checking bench for mc_mem_responder. Two instances are
//             built: index 0 with zero wait states, index 1 with the default
//             two. A timeline model (memory array plus a busy countdown per
//             instance) predicts every output each cycle; directed sequences
//             add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mc_mem_responder;

  localparam int AW        = 6;
  localparam int MEM_WORDS = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // stimulus per instance
  logic        rv   [2];
  logic        rwe  [2];
  logic [31:0] ra   [2];
  logic [31:0] rwd  [2];
  logic        ld_en  [2];
  logic [5:0]  ld_addr[2];
  logic [31:0] ld_data[2];

  // observed outputs per instance
  logic        rdy_w  [2];
  logic        rvld_w [2];
  logic [31:0] rdata_w[2];
  logic        err_w  [2];

  mc_mem_responder_if if0();
  mc_mem_responder_if if1();

  assign if0.req_valid = rv[0];
  assign if0.req_we    = rwe[0];
  assign if0.req_addr  = ra[0];
  assign if0.req_wdata = rwd[0];
  assign if1.req_valid = rv[1];
  assign if1.req_we    = rwe[1];
  assign if1.req_addr  = ra[1];
  assign if1.req_wdata = rwd[1];

  assign rdy_w[0]   = if0.req_ready;
  assign rvld_w[0]  = if0.resp_valid;
  assign rdata_w[0] = if0.resp_rdata;
  assign err_w[0]   = if0.resp_err;
  assign rdy_w[1]   = if1.req_ready;
  assign rvld_w[1]  = if1.resp_valid;
  assign rdata_w[1] = if1.resp_rdata;
  assign err_w[1]   = if1.resp_err;

  mc_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst), .bus(if0),
    .i_load_en(ld_en[0]), .i_load_addr(ld_addr[0]), .i_load_data(ld_data[0])
  );

  mc_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) dut1 (
    .clk(clk), .reset(rst), .bus(if1),
    .i_load_en(ld_en[1]), .i_load_addr(ld_addr[1]), .i_load_data(ld_data[1])
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%h required=%h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  // ---------------------------------------------------------------- model
  // busy counts the cycles during which req_ready must stay low after an
  // acceptance (wait states + response cycle); busy==1 marks the response.
  int          m_busy [2];
  logic [31:0] m_mem  [2][MEM_WORDS];
  bit          m_kn   [2][MEM_WORDS];
  logic        p_we   [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wd   [2];
  logic [31:0] m_rdata[2];
  logic        m_err  [2];
  bit          m_known[2];
  bit          m_acc, m_ld;
  int          m_idx;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i]  = 0;
        m_rdata[i] = 32'h0;
        m_err[i]   = 1'b0;
        m_known[i] = 1'b1;
      end else begin
        m_acc = (m_busy[i] == 0) && !ld_en[i] && rv[i];
        m_ld  = (m_busy[i] == 0) && ld_en[i];
        if (m_busy[i] > 0) m_busy[i] = m_busy[i] - 1;
        if (m_ld) begin
          m_mem[i][ld_addr[i]] = ld_data[i];
          m_kn[i][ld_addr[i]]  = 1'b1;
        end
        if (m_acc) begin
          p_we[i]   = rwe[i];
          p_addr[i] = ra[i];
          p_wd[i]   = rwd[i];
          m_busy[i] = wait_of(i) + 1;
        end
        if (m_busy[i] == 1) begin
          if ((p_addr[i] % 4) != 0 || p_addr[i] >= 4 * MEM_WORDS) begin
            m_err[i]   = 1'b1;
            m_rdata[i] = 32'h0;
            m_known[i] = 1'b1;
          end else begin
            m_idx    = int'(p_addr[i] / 4);
            m_err[i] = 1'b0;
            if (p_we[i]) begin
              m_mem[i][m_idx] = p_wd[i];
              m_kn[i][m_idx]  = 1'b1;
              m_rdata[i]      = 32'h0;
              m_known[i]      = 1'b1;
            end else begin
              m_rdata[i] = m_mem[i][m_idx];
              m_known[i] = m_kn[i][m_idx];
            end
          end
        end
      end
    end
  end

  // -------------------------------------------------------------- compare
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          chk("ready", i, rdy_w[i], 0);
          chk("resp_valid", i, rvld_w[i], 0);
          chk("resp_err", i, err_w[i], 0);
          chk("resp_rdata", i, rdata_w[i], 0);
        end else begin
          chk("ready", i, rdy_w[i], (m_busy[i] == 0) && !ld_en[i]);
          chk("resp_valid", i, rvld_w[i], m_busy[i] == 1);
          chk("resp_err", i, err_w[i], m_err[i]);
          if (m_known[i]) chk("resp_rdata", i, rdata_w[i], m_rdata[i]);
        end
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic load_word(input int i, input logic [5:0] idx, input logic [31:0] d);
    @(negedge clk);
    ld_en[i] = 1'b1; ld_addr[i] = idx; ld_data[i] = d;
    @(negedge clk);
    ld_en[i] = 1'b0;
  endtask

  // Called right after the acceptance edge; lat counts edges including it.
  task automatic finish_req(input int i, output logic [31:0] rd, output logic er, output int lat);
    lat = 1;
    @(negedge clk);
    rv[i] = 1'b0;
    while (!rvld_w[i] && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!rvld_w[i]) chk("resp_timeout", i, 0, 1);
    rd = rdata_w[i];
    er = err_w[i];
  endtask

  task automatic do_req(input int i, input logic we, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    rv[i] = 1'b1; rwe[i] = we; ra[i] = a; rwd[i] = d;
    #1;
    n = 0;
    while (!rdy_w[i] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!rdy_w[i]) begin
      chk("accept_timeout", i, 0, 1);
      rv[i] = 1'b0;
      rd = 32'hx; er = 1'bx; lat = -1;
    end else begin
      @(posedge clk);
      finish_req(i, rd, er, lat);
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          nacc, nresp, nv;
  bit          acc_now;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rv[i] = 0; rwe[i] = 0; ra[i] = 0; rwd[i] = 0;
      ld_en[i] = 0; ld_addr[i] = 0; ld_data[i] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", 1, rdy_w[1], 0);
    chk("reset_rdata", 1, rdata_w[1], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_ready", 0, rdy_w[0], 1);
    chk("idle_ready", 1, rdy_w[1], 1);

    // preload and read back
    load_word(1, 6'd3, 32'hE3A0_1005);
    load_word(1, 6'd0, 32'h5555_0000);
    do_req(1, 1'b0, 32'h0000_000C, 32'h0, rd, er, lat);
    chk("preload_rdata", 1, rd, 32'hE3A0_1005);
    chk("preload_err", 1, er, 0);
    chk("preload_latency", 1, lat, 3);

    // write then read
    do_req(1, 1'b1, 32'h0000_0010, 32'h1234_5678, rd, er, lat);
    chk("write_rdata", 1, rd, 32'h0);
    chk("write_err", 1, er, 0);
    chk("write_latency", 1, lat, 3);
    do_req(1, 1'b0, 32'h0000_0010, 32'h0, rd, er, lat);
    chk("raw_rdata", 1, rd, 32'h1234_5678);

    // error cases
    do_req(1, 1'b0, 32'h0000_0006, 32'h0, rd, er, lat);
    chk("misaligned_err", 1, er, 1);
    chk("misaligned_rdata", 1, rd, 32'h0);
    do_req(1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, rd, er, lat);
    chk("range_err", 1, er, 1);
    chk("range_rdata", 1, rd, 32'h0);
    do_req(1, 1'b0, 32'h0000_0000, 32'h0, rd, er, lat);
    chk("word0_unchanged", 1, rd, 32'h5555_0000);
    chk("word0_err", 1, er, 0);

    // zero-wait instance: back-to-back reads with req_valid held
    for (int k = 0; k < 8; k++) load_word(0, 6'(k), 32'hC0DE_0000 + 32'(k));
    @(negedge clk);
    rv[0] = 1'b1; rwe[0] = 1'b0; ra[0] = 32'h0;
    nacc = 0; nresp = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      acc_now = rdy_w[0];
      @(posedge clk);
      #1;
      if (rvld_w[0]) begin
        chk("b2b_rdata", 0, rdata_w[0], 32'hC0DE_0000 + 32'(nresp));
        nresp++;
      end
      @(negedge clk);
      if (acc_now) begin
        nacc++;
        ra[0] = 32'(4 * nacc);
      end
    end
    rv[0] = 1'b0;
    chk("b2b_accepts", 0, nacc, 6);
    chk("b2b_responses", 0, nresp, 6);
    do_req(0, 1'b0, 32'h0000_0008, 32'h0, rd, er, lat);
    chk("w0_latency", 0, lat, 1);
    chk("w0_rdata", 0, rd, 32'hC0DE_0002);

    // reset while a write is in its wait states
    load_word(1, 6'd8, 32'hAAAA_AAAA);
    @(negedge clk);
    rv[1] = 1'b1; rwe[1] = 1'b1; ra[1] = 32'h20; rwd[1] = 32'h1111_1111;
    #1;
    chk("abort_ready", 1, rdy_w[1], 1);
    @(posedge clk);
    @(negedge clk);
    rv[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (rvld_w[1]) nv++;
    end
    chk("abort_no_resp", 1, nv, 0);
    do_req(1, 1'b0, 32'h0000_0020, 32'h0, rd, er, lat);
    chk("abort_old_data", 1, rd, 32'hAAAA_AAAA);

    // load and request together: load wins, request follows
    @(negedge clk);
    ld_en[1] = 1'b1; ld_addr[1] = 6'd9; ld_data[1] = 32'h9999_0009;
    rv[1] = 1'b1; rwe[1] = 1'b0; ra[1] = 32'h24;
    #1;
    chk("load_blocks_ready", 1, rdy_w[1], 0);
    @(negedge clk);
    ld_en[1] = 1'b0;
    #1;
    chk("ready_after_load", 1, rdy_w[1], 1);
    @(posedge clk);
    finish_req(1, rd, er, lat);
    chk("load_then_read", 1, rd, 32'h9999_0009);
    chk("load_then_read_lat", 1, lat, 3);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
